// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared ALU opcode, pipeline stage type and decode helpers
package ariane_pkg;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'd0,
    ALU_SUB  = 6'd1,
    ALU_AND  = 6'd2,
    ALU_OR   = 6'd3,
    ALU_XOR  = 6'd4,
    ALU_SLL  = 6'd5,
    ALU_SRL  = 6'd6,
    ALU_SRA  = 6'd7,
    ALU_SLTS = 6'd8,
    ALU_SLTU = 6'd9,
    ALU_MIN  = 6'd10,
    ALU_MAX  = 6'd11,
    ALU_MINU = 6'd12,
    ALU_MAXU = 6'd13,
    ALU_CLZ  = 6'd14,
    ALU_CTZ  = 6'd15,
    ALU_CPOP = 6'd16,
    ALU_EQ   = 6'd17,
    ALU_NE   = 6'd18,
    ALU_LTS  = 6'd19,
    ALU_GES  = 6'd20,
    ALU_LTU  = 6'd21,
    ALU_GEU  = 6'd22,
    ALU_ADDW = 6'd23,
    ALU_SUBW = 6'd24,
    ALU_SLLW = 6'd25,
    ALU_SRLW = 6'd26,
    ALU_SRAW = 6'd27
  } alu_op_e;

  localparam int OP_W = $bits(alu_op_e);

  // Stage payload is sized for the widest legal configuration; narrower
  // instances zero-extend into it and slice back out at the output.
  localparam int XLEN_MAX = 64;
  localparam int TID_MAX  = 8;

  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] result;
    logic                branch;
    logic                illegal;
    logic [TID_MAX-1:0]  trans_id;
  } alu_stage_t;

  function automatic logic is_word_op(alu_op_e op);
    return op inside {ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW};
  endfunction

  function automatic logic is_branch_op(alu_op_e op);
    return op inside {ALU_EQ, ALU_NE, ALU_LTS, ALU_GES, ALU_LTU, ALU_GEU};
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// rtl/alu_pipe_stage.sv - one elastic register stage with clear and async reset
module alu_pipe_stage
  import ariane_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  alu_stage_t data_i,
  output logic       ready_o,
  output alu_stage_t data_o,
  input  logic       ready_i
);

  alu_stage_t r_q;

  // Accept new contents when empty or when the current contents leave this cycle.
  assign ready_o = ~r_q.valid | ready_i;
  assign data_o  = r_q;

  // Stage register; clear kills the held op and drops the incoming one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= '0;
    end else if (clear_i) begin
      r_q.valid <= 1'b0;
    end else if (ready_o) begin
      r_q <= data_i;
    end
  end

endmodule

// File: rtl/alu_pipelined.sv
// rtl/alu_pipelined.sv - parametrised elastic execute-stage integer ALU
module alu_pipelined
  import ariane_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int LATENCY       = 2,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [OP_W-1:0]          operator_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic                     branch_res_o,
  output logic                     illegal_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  localparam int SHW = $clog2(XLEN);

  alu_op_e           w_op;
  logic [SHW-1:0]    w_shamt;
  logic [31:0]       w_word;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_clz;
  logic [XLEN-1:0]   w_ctz;
  logic [XLEN-1:0]   w_cpop;
  logic [XLEN-1:0]   w_result;
  logic              w_cmp;
  logic              w_illegal;
  logic              w_branch;
  alu_stage_t        w_stage [LATENCY+1];
  logic [LATENCY:0]  w_ready;
  logic              w_unused;

  assign w_op    = alu_op_e'(operator_i);
  assign w_shamt = operand_b_i[SHW-1:0];

  // Leading/trailing zero and population counts of operand_a; zero input gives XLEN.
  always_comb begin
    w_clz  = XLEN'(XLEN);
    w_ctz  = XLEN'(XLEN);
    w_cpop = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (operand_a_i[i]) w_clz = XLEN'(XLEN - 1 - i);
      if (operand_a_i[XLEN-1-i]) w_ctz = XLEN'(XLEN - 1 - i);
      w_cpop = w_cpop + XLEN'(operand_a_i[i]);
    end
  end

  // Opcode decode: arithmetic/logic result, branch compare and 32-bit word result.
  always_comb begin
    w_alu     = '0;
    w_cmp     = 1'b0;
    w_word    = '0;
    w_illegal = 1'b0;
    case (w_op)
      ALU_ADD:  w_alu = operand_a_i + operand_b_i;
      ALU_SUB:  w_alu = operand_a_i - operand_b_i;
      ALU_AND:  w_alu = operand_a_i & operand_b_i;
      ALU_OR:   w_alu = operand_a_i | operand_b_i;
      ALU_XOR:  w_alu = operand_a_i ^ operand_b_i;
      ALU_SLL:  w_alu = operand_a_i << w_shamt;
      ALU_SRL:  w_alu = operand_a_i >> w_shamt;
      ALU_SRA:  w_alu = XLEN'($signed(operand_a_i) >>> w_shamt);
      ALU_SLTS: w_alu = XLEN'($signed(operand_a_i) < $signed(operand_b_i));
      ALU_SLTU: w_alu = XLEN'(operand_a_i < operand_b_i);
      ALU_MIN:  w_alu = ($signed(operand_a_i) < $signed(operand_b_i)) ? operand_a_i : operand_b_i;
      ALU_MAX:  w_alu = ($signed(operand_a_i) < $signed(operand_b_i)) ? operand_b_i : operand_a_i;
      ALU_MINU: w_alu = (operand_a_i < operand_b_i) ? operand_a_i : operand_b_i;
      ALU_MAXU: w_alu = (operand_a_i < operand_b_i) ? operand_b_i : operand_a_i;
      ALU_CLZ:  w_alu = w_clz;
      ALU_CTZ:  w_alu = w_ctz;
      ALU_CPOP: w_alu = w_cpop;
      ALU_EQ:   w_cmp = (operand_a_i == operand_b_i);
      ALU_NE:   w_cmp = (operand_a_i != operand_b_i);
      ALU_LTS:  w_cmp = ($signed(operand_a_i) < $signed(operand_b_i));
      ALU_GES:  w_cmp = ($signed(operand_a_i) >= $signed(operand_b_i));
      ALU_LTU:  w_cmp = (operand_a_i < operand_b_i);
      ALU_GEU:  w_cmp = (operand_a_i >= operand_b_i);
      ALU_ADDW: w_word = operand_a_i[31:0] + operand_b_i[31:0];
      ALU_SUBW: w_word = operand_a_i[31:0] - operand_b_i[31:0];
      ALU_SLLW: w_word = operand_a_i[31:0] << operand_b_i[4:0];
      ALU_SRLW: w_word = operand_a_i[31:0] >> operand_b_i[4:0];
      ALU_SRAW: w_word = $signed(operand_a_i[31:0]) >>> operand_b_i[4:0];
      default:  w_illegal = 1'b1;
    endcase
    if (is_word_op(w_op)) begin
      w_alu = XLEN'($signed(w_word));
      if (XLEN != 64) w_illegal = 1'b1;
    end
  end

  // Branch and illegal ops return a zero result; only branches drive branch_res.
  always_comb begin
    w_result = w_alu;
    w_branch = 1'b0;
    if (w_illegal) begin
      w_result = '0;
    end else if (is_branch_op(w_op)) begin
      w_result = '0;
      w_branch = w_cmp;
    end
  end

  // Pack the computed op into the first stage's input payload.
  always_comb begin
    w_stage[0]          = '0;
    w_stage[0].valid    = valid_i;
    w_stage[0].result   = XLEN_MAX'(w_result);
    w_stage[0].branch   = w_branch;
    w_stage[0].illegal  = w_illegal;
    w_stage[0].trans_id = TID_MAX'(trans_id_i);
  end

  assign w_ready[LATENCY] = ready_i;
  assign ready_o          = w_ready[0];

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    alu_pipe_stage u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (flush_i),
      .data_i  (w_stage[k]),
      .ready_o (w_ready[k]),
      .data_o  (w_stage[k+1]),
      .ready_i (w_ready[k+1])
    );
  end

  assign valid_o      = w_stage[LATENCY].valid;
  assign result_o     = w_stage[LATENCY].result[XLEN-1:0];
  assign branch_res_o = w_stage[LATENCY].branch;
  assign illegal_o    = w_stage[LATENCY].illegal;
  assign trans_id_o   = w_stage[LATENCY].trans_id[TRANS_ID_BITS-1:0];

  // Payload bits above the configured widths are never read out.
  assign w_unused = ^w_stage[LATENCY];

endmodule

// File: tb/tb_alu_pipelined.sv
// tb/tb_alu_pipelined.sv - randomized and directed bench for alu_pipelined
module tb_alu_pipelined;
  import ariane_pkg::*;

  localparam int XLEN = 64;
  localparam int LATENCY = 2;
  localparam int TIDB = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  logic [OP_W-1:0] operator_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic [TIDB-1:0] trans_id_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            branch_res_o;
  logic            illegal_o;
  logic [TIDB-1:0] trans_id_o;

  alu_pipelined #(.XLEN(XLEN), .LATENCY(LATENCY), .TRANS_ID_BITS(TIDB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .operator_i   (operator_i),
    .operand_a_i  (operand_a_i),
    .operand_b_i  (operand_b_i),
    .trans_id_i   (trans_id_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .branch_res_o (branch_res_o),
    .illegal_o    (illegal_o),
    .trans_id_o   (trans_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] res;
    logic        br;
    logic        il;
    logic [2:0]  id;
  } exp_t;

  exp_t        exp_q[$];
  logic [2:0]  emitted[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        last_acc, last_hs, last_ready, last_valid, prev_stall;
  exp_t        last_out, held;

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the opcode rules, using plain integer arithmetic.
  function automatic exp_t ref_model(logic [5:0] op, logic [63:0] a, logic [63:0] b, logic [2:0] id);
    exp_t e;
    longint sa, sbv;
    int sh, w, n;
    int unsigned u;
    sa = a; sbv = b; sh = int'(b[5:0]);
    e.res = 0; e.br = 0; e.il = 0; e.id = id;
    case (op)
      ALU_ADD:  e.res = a + b;
      ALU_SUB:  e.res = a - b;
      ALU_AND:  e.res = a & b;
      ALU_OR:   e.res = a | b;
      ALU_XOR:  e.res = a ^ b;
      ALU_SLL:  e.res = a << sh;
      ALU_SRL:  e.res = a >> sh;
      ALU_SRA:  e.res = sa >>> sh;
      ALU_SLTS: e.res = (sa < sbv) ? 1 : 0;
      ALU_SLTU: e.res = (a < b) ? 1 : 0;
      ALU_MIN:  e.res = (sa <= sbv) ? a : b;
      ALU_MAX:  e.res = (sa >= sbv) ? a : b;
      ALU_MINU: e.res = (a <= b) ? a : b;
      ALU_MAXU: e.res = (a >= b) ? a : b;
      ALU_CLZ:  begin n = 0; while (n < 64 && a[63-n] == 1'b0) n++; e.res = n; end
      ALU_CTZ:  begin n = 0; while (n < 64 && a[n] == 1'b0) n++; e.res = n; end
      ALU_CPOP: e.res = $countones(a);
      ALU_EQ:   e.br = (a == b);
      ALU_NE:   e.br = (a != b);
      ALU_LTS:  e.br = (sa < sbv);
      ALU_GES:  e.br = (sa >= sbv);
      ALU_LTU:  e.br = (a < b);
      ALU_GEU:  e.br = (a >= b);
      ALU_ADDW: begin w = int'(a[31:0]) + int'(b[31:0]); e.res = longint'(w); end
      ALU_SUBW: begin w = int'(a[31:0]) - int'(b[31:0]); e.res = longint'(w); end
      ALU_SLLW: begin u = a[31:0]; u = u << b[4:0]; e.res = longint'(int'(u)); end
      ALU_SRLW: begin u = a[31:0]; u = u >> b[4:0]; e.res = longint'(int'(u)); end
      ALU_SRAW: begin w = int'(a[31:0]); w = w >>> b[4:0]; e.res = longint'(w); end
      default:  e.il = 1;
    endcase
    return e;
  endfunction

  // One clock: sample at negedge, score handshakes, return just after posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk_i);
    last_ready = ready_o;
    last_valid = valid_o;
    last_out.res = result_o; last_out.br = branch_res_o;
    last_out.il = illegal_o; last_out.id = trans_id_o;
    if (!rst_i) begin
      if (prev_stall) begin
        check_eq("hold_valid", valid_o, 1);
        check_eq("hold_result", result_o, held.res);
        check_eq("hold_branch", branch_res_o, held.br);
        check_eq("hold_id", trans_id_o, held.id);
      end
      last_hs  = valid_o && ready_i;
      last_acc = valid_i && ready_o && !flush_i;
      if (last_hs) begin
        emitted.push_back(trans_id_o);
        check_eq("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("out_result", result_o, e.res);
          check_eq("out_branch", branch_res_o, e.br);
          check_eq("out_illegal", illegal_o, e.il);
          check_eq("out_id", trans_id_o, e.id);
        end
      end
      if (flush_i) exp_q.delete();
      if (last_acc) exp_q.push_back(ref_model(operator_i, operand_a_i, operand_b_i, trans_id_i));
      prev_stall = valid_o && !ready_i && !flush_i;
      held = last_out;
    end else begin
      last_hs = 0; last_acc = 0; prev_stall = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(logic [5:0] op, logic [63:0] a, logic [63:0] b, logic [2:0] id);
    operator_i = op; operand_a_i = a; operand_b_i = b; trans_id_i = id; valid_i = 1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (last_acc) break;
    end
    check_eq("issue_accepted", last_acc, 1);
    valid_i = 0;
  endtask

  task automatic run_one(string tag, logic [5:0] op, logic [63:0] a, logic [63:0] b, logic [2:0] id,
                         logic [63:0] er, logic eb, logic ei);
    int lat;
    lat = 0;
    ready_i = 1;
    issue(op, a, b, id);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (last_hs) begin lat = k; break; end
    end
    check_eq({tag, "_latency"}, lat, LATENCY);
    check_eq({tag, "_ready"}, last_ready, 1);
    check_eq({tag, "_result"}, last_out.res, er);
    check_eq({tag, "_branch"}, last_out.br, eb);
    check_eq({tag, "_illegal"}, last_out.il, ei);
    check_eq({tag, "_id"}, last_out.id, id);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    logic [5:0] op;
    rst_i = 1; flush_i = 0; valid_i = 0; ready_i = 1; prev_stall = 0;
    operator_i = '0; operand_a_i = '0; operand_b_i = '0; trans_id_i = '0;
    cycle();
    check_eq("rst_valid", last_valid, 0);
    check_eq("rst_result", last_out.res, 0);
    check_eq("rst_branch", last_out.br, 0);
    check_eq("rst_illegal", last_out.il, 0);
    check_eq("rst_id", last_out.id, 0);
    check_eq("rst_ready", last_ready, 1);
    rst_i = 0;

    run_one("add", ALU_ADD, 64'h1, 64'h2, 3, 64'h3, 0, 0);
    run_one("subw", ALU_SUBW, 64'h1, 64'h2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_one("sraw", ALU_SRAW, 64'h8000_0000, 64'h21, 2, 64'hFFFF_FFFF_C000_0000, 0, 0);
    run_one("sra", ALU_SRA, 64'h8000_0000_0000_0000, 64'h1, 4, 64'hC000_0000_0000_0000, 0, 0);
    run_one("clz0", ALU_CLZ, 64'h0, 64'h0, 5, 64'd64, 0, 0);
    run_one("ctz", ALU_CTZ, 64'h100, 64'h0, 6, 64'd8, 0, 0);
    run_one("cpop", ALU_CPOP, 64'hFF00, 64'h0, 7, 64'd8, 0, 0);
    run_one("minu", ALU_MINU, '1, 64'h2, 0, 64'h2, 0, 0);
    run_one("max", ALU_MAX, '1, 64'h2, 1, 64'h2, 0, 0);
    run_one("lts", ALU_LTS, '1, 64'h2, 2, 64'h0, 1, 0);

    // Backpressure: only LATENCY ops fit while the output is stalled.
    emitted.delete();
    ready_i = 0; id = 0;
    for (int c = 0; c < 6; c++) begin
      operator_i = ALU_ADD; operand_a_i = 64'(id); operand_b_i = 64'h10;
      trans_id_i = 3'(id); valid_i = 1;
      cycle();
      if (last_acc) id++;
    end
    check_eq("bp_accepted", id, LATENCY);
    check_eq("bp_ready_low", last_ready, 0);
    ready_i = 1;
    for (int c = 0; c < 40; c++) begin
      valid_i = (id < 5);
      operand_a_i = 64'(id); trans_id_i = 3'(id);
      cycle();
      if (last_acc) id++;
      if (id >= 5 && exp_q.size() == 0) break;
    end
    valid_i = 0;
    check_eq("bp_count", emitted.size(), 5);
    for (int i = 0; i < emitted.size() && i < 5; i++) check_eq("bp_order", emitted[i], i);

    // Flush with both stages full and a new op presented in the same cycle.
    ready_i = 0;
    issue(ALU_XOR, 64'hAA, 64'h55, 1);
    issue(ALU_OR, 64'hA0, 64'h05, 2);
    operator_i = ALU_ADD; operand_a_i = 64'h7; trans_id_i = 7; valid_i = 1; flush_i = 1;
    cycle();
    flush_i = 0; valid_i = 0;
    cycle();
    check_eq("flush_valid", last_valid, 0);
    check_eq("flush_ready", last_ready, 1);
    emitted.delete();
    run_one("post_flush", ALU_ADD, 64'h5, 64'h5, 5, 64'hA, 0, 0);
    for (int c = 0; c < 4; c++) cycle();
    check_eq("flush_emitted", emitted.size(), 1);
    check_eq("flush_only_id", emitted[0], 5);

    run_one("illegal", 6'h3F, 64'h1234, 64'h5678, 6, 64'h0, 0, 1);

    // Randomized mixed traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      op = ($urandom % 10 == 0) ? 6'($urandom_range(28, 63)) : 6'($urandom_range(0, 27));
      operator_i  = op;
      operand_a_i = ($urandom % 6 == 0) ? 64'h0 : (($urandom % 3 == 0) ? 64'($urandom % 16) : {$urandom, $urandom});
      operand_b_i = ($urandom % 4 == 0) ? operand_a_i : {$urandom, $urandom};
      trans_id_i  = 3'(i);
      valid_i     = ($urandom % 4 != 0);
      ready_i     = ($urandom % 3 != 0);
      flush_i     = ($urandom % 40 == 0);
      cycle();
    end
    valid_i = 0; flush_i = 0; ready_i = 1;
    for (int c = 0; c < 10; c++) cycle();
    check_eq("drain_empty", exp_q.size(), 0);

    // Asynchronous reset while the pipeline holds stalled results.
    ready_i = 0;
    issue(ALU_ADD, 64'h11, 64'h22, 3);
    issue(ALU_SUB, 64'h11, 64'h22, 4);
    cycle();
    check_eq("pre_reset_valid", last_valid, 1);
    #2 rst_i = 1;
    #1;
    check_eq("arst_valid", valid_o, 0);
    check_eq("arst_result", result_o, 0);
    check_eq("arst_id", trans_id_o, 0);
    check_eq("arst_ready", ready_o, 1);
    exp_q.delete(); prev_stall = 0;
    cycle();
    rst_i = 0;
    run_one("post_reset", ALU_AND, 64'hF0F0, 64'hFF00, 2, 64'hF000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipelined.md
Name: alu_pipelined

Overview:
- Parametrised, elastic successor to the single-cycle integer ALU for the execute stage.
- Adds configurable XLEN and pipeline depth, a valid/ready handshake on both sides, and transaction-ID tagging.
- Adds flush, 32-bit word ops on RV64, min/max and count (CLZ/CTZ/CPOP) ops, and an illegal-op flag.
- Sits between issue and the writeback arbiter; results return in order.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64.
- LATENCY, 2, number of register stages from input to output; legal range is 1..4.
- TRANS_ID_BITS, 3, width of the scoreboard tag.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  kill all in-flight operations.
- valid_i  in  1  input operation valid.
- ready_o  out  1  ALU can accept an operation this cycle.
- operator_i  in  OP_W  alu_op_e opcode.
- operand_a_i  in  XLEN  rs1 value.
- operand_b_i  in  XLEN  rs2 or immediate value.
- trans_id_i  in  TRANS_ID_BITS  scoreboard tag.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  XLEN  operation result.
- branch_res_o  out  1  comparison outcome for branch ops.
- illegal_o  out  1  operator was not decodable.
- trans_id_o  out  TRANS_ID_BITS  tag returned with the result.

Behaviour:
- Reset: clk_i and rst_i are one clock and an asynchronous active-high reset. On reset, every stage valid = 0; valid_o, result_o, branch_res_o, illegal_o and trans_id_o = 0; ready_o = 1.
- Compute: result is computed combinationally from the inputs, then carried through LATENCY elastic register stages. Stage k holds {valid, result, branch, illegal, id}.
- Stage advance: stage k loads from stage k-1 when (stage k empty) or (stage k advances this cycle). The last stage advances when valid_o && ready_i.
- Ready: ready_o = ~valid[0] | advance[0]. A full-throughput bubble-free stream sustains 1 op/cycle. The input is accepted on valid_i && ready_o.
- Latency: with ready_i held high, an op accepted in cycle N has valid_o = 1 in cycle N+LATENCY.
- Backpressure: when ready_i = 0, the output holds all fields stable. Upstream stages fill and ready_o drops only when every stage is full, i.e. after LATENCY accepted ops stall. No op is ever dropped or duplicated.
- Flush: flush_i clears all stage valids on the next edge. An input presented in the same cycle as flush_i is dropped. valid_o = 0 and ready_o = 1 in the following cycle. Data fields need not be cleared.
- Arithmetic and logic ops: ADD, SUB, AND, OR, XOR.
- Shifts: SLL, SRL, SRA use operand_b[$clog2(XLEN)-1:0].
- Compares: SLTS and SLTU produce 0/1 zero-extended. MIN, MAX, MINU, MAXU produce the selected operand.
- Counts: CLZ and CTZ return XLEN when operand_a = 0. CPOP counts ones.
- Branch ops: EQ, NE, LTS, GES, LTU, GEU set branch_res_o and leave result_o = 0.
- Word ops (XLEN=64 only): ADDW, SUBW, SLLW, SRLW, SRAW use operand_b[4:0]. They operate on the low 32 bits and sign-extend bit 31 into the result. When XLEN=32 these are illegal.
- Illegal opcode: illegal_o = 1, result_o = 0, branch_res_o = 0. The op still flows and returns its trans_id.
- Overflow: add and subtract wrap modulo 2^XLEN; there is no overflow flag.

Decomposition:
- ariane_pkg holds:
  - alu_op_e enum, with OP_W derived from it;
  - an alu_stage_t struct {valid, result, branch, illegal, trans_id};
  - an is_word_op() function;
  - an is_branch_op() function.
- Sub-module alu_pipe_stage: one elastic register stage with in/out valid/ready, clear input and async reset. It is instantiated LATENCY times via generate.
- The combinational datapath stays inline in alu_pipelined.

Test Plan (XLEN=64, LATENCY=2):
- Reset, then ADD a=0x1 b=0x2 id=3 with ready_i=1 -> valid_o two cycles after acceptance, result 0x3, trans_id_o 3; ready_o stays 1.
- SUBW a=0x1 b=0x2 -> result 0xFFFF_FFFF_FFFF_FFFF. SRAW a=0x8000_0000 b=0x21 -> shift 1, result 0xFFFF_FFFF_C000_0000. SRA a=0x8000_0000_0000_0000 b=1 -> 0xC000_0000_0000_0000.
- CLZ a=0 -> 64. CTZ a=0x100 -> 8. CPOP a=0xFF00 -> 8. MINU a=-1 b=2 -> 2. MAX a=-1 b=2 -> 2. LTS a=-1 b=2 -> branch_res_o 1, result 0.
- Issue 5 back-to-back ops (ids 0..4) with ready_i=0 -> ready_o drops after 2 accepted ops. Then set ready_i=1 -> ids emerge in order 0..4, each exactly once, with output fields stable while stalled.
- Fill both stages, assert flush_i together with valid_i -> next cycle valid_o=0 and ready_o=1. The next op has id 5 and emerges with id 5 only.
- Undefined opcode 0x3F id=6 -> illegal_o=1, result 0, id 6. Assert rst_i mid-stream -> outputs 0 asynchronously, ready_o=1.
